// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM transmitter/receiver pair.
package tdm_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {HUNT, LOCKED} tdm_state_t;

   typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Mod-4 slot counter with clear, load-to-1 and increment enable.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   input  logic  load,
   input  logic  clr,
   output slot_t slot,
   output logic  last
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         slot <= '0;
      else if (clr)
         slot <= '0;
      else if (load)
         slot <= slot_t'(1);
      else if (en)
         slot <= slot + slot_t'(1);
   end

   assign last = (slot == slot_t'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: frame alignment, shadow capture,
// and frame-coherent registered outputs.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err,
   output slot_t            slot
);

   tdm_state_t       state;
   logic [WIDTH-1:0] sh0, sh1, sh2;
   logic             is_lock, at0, last;
   logic             load, clr, inc, err;

   assign is_lock = (state == LOCKED);
   assign at0     = (slot == '0);

   // A synced beat always restarts the frame at slot 0, in either state.
   assign load = din_valid & frame_sync;
   assign clr  = din_valid & is_lock & ~frame_sync & at0;
   assign inc  = din_valid & is_lock & ~frame_sync & ~at0;
   assign err  = din_valid & is_lock & (frame_sync ^ at0);

   tdm_slot_ctr u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (inc),
      .load  (load),
      .clr   (clr),
      .slot  (slot),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= HUNT;
         sh0         <= '0;
         sh1         <= '0;
         sh2         <= '0;
         y0          <= '0;
         y1          <= '0;
         y2          <= '0;
         y3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= inc & last;
         sync_err    <= err;
         if (load)
            state <= LOCKED;
         else if (clr)
            state <= HUNT;
         if (load)
            sh0 <= din;
         if (inc && slot == slot_t'(1))
            sh1 <= din;
         if (inc && slot == slot_t'(2))
            sh2 <= din;
         // Slot 3 comes straight from din so the frame lands in one edge.
         if (inc && last) begin
            y0 <= sh0;
            y1 <= sh1;
            y2 <= sh2;
            y3 <= din;
         end
      end
   end

   assign locked = is_lock;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: takes a framed serial stream (one slot per valid beat, slot 0 marked by `frame_sync`) and distributes slots 0..3 onto four registered, frame-coherent outputs. It is the receiving end of the team's 4:1 selection path. A transmitter scans i0..i3 onto one wire, and this block recovers them. It also handles frame alignment, loss of sync, and stalls.

## Interface
Parameters:
- `WIDTH`, 1: bits per slot.

Ports:
- `clk`  in  1  Single clock; all logic on the rising edge.
- `rst_n`  in  1  Reset; synchronous, active-low.
- `din`  in  WIDTH  Slot data.
- `din_valid`  in  1  `din` carries a slot beat this cycle. Low means stall with no state change.
- `frame_sync`  in  1  Marks the current valid beat as slot 0. Ignored when `din_valid` is low.
- `y0`, `y1`, `y2`, `y3`  out  WIDTH each  Last complete frame, slots 0..3. Updated together.
- `frame_valid`  out  1  One-cycle pulse when `y0..y3` are updated.
- `locked`  out  1  High while aligned to a frame.
- `sync_err`  out  1  One-cycle pulse on an alignment error.
- `slot`  out  2  Slot index expected for the next valid beat.

## Operation
- States: HUNT and LOCKED.
- Reset values: state HUNT; `slot` 0; `y0..y3`, shadow registers, `frame_valid`, `sync_err` and `locked` all 0.
- HUNT:
  - A valid beat without `frame_sync` is discarded.
  - A valid beat with `frame_sync` writes shadow[0]. Then `slot` becomes 1 and the state goes to LOCKED.
- LOCKED, valid beat, no error:
  - Writes shadow[`slot`], then `slot` = `slot` + 1 mod 4 (wraps 3→0).
  - The slot-3 beat copies shadow[0..2] and `din` into `y0..y2`, `y3`, and asserts `frame_valid`.
  - `frame_sync` coinciding with the slot-0 beat is the normal case; it is not an error.
- LOCKED errors:
  - Valid beat with `frame_sync` at `slot` ≠ 0: `sync_err` pulse. The partial frame is discarded, and `y*` are not updated. The beat is taken as slot 0 (shadow[0] written, `slot` = 1), and the state stays LOCKED.
  - Valid beat without `frame_sync` at `slot` = 0: `sync_err` pulse. The beat is discarded, `slot` stays 0, and the state goes to HUNT.
- `din_valid` low: no state, slot or shadow change. Stalls may occur mid-frame without limit.
- `locked` = (state == LOCKED), registered.
- `y0..y3` hold their value between frames and across HUNT. They change only on a completed frame.
- Reset mid-frame: the partial frame is lost and all outputs return to their reset values on the next edge.

## Timing
- All outputs are registered.
- A slot-3 beat accepted at edge N gives `y0..y3` new values and `frame_valid` = 1 in cycle N+1. `frame_valid` is back to 0 in cycle N+2 unless another frame completes.
- Minimum frame is 4 consecutive valid beats, so back-to-back frames give `frame_valid` every 4th cycle.
- `sync_err` is high in the cycle after the offending beat, for 1 cycle.
- `locked` rises in the cycle after the first accepted `frame_sync` beat. It falls in the cycle after a missing-sync error.
- `slot` reflects the post-edge value; it is combinationally usable by the sender as "next expected slot".
- No throughput loss: one slot per cycle is sustained indefinitely while aligned.

## Structure
- Shared package `tdm_pkg` holds:
  - `localparam NUM_SLOTS = 4`, `SLOT_W = 2`.
  - `typedef enum logic {HUNT, LOCKED} tdm_state_t`.
  - `typedef logic [SLOT_W-1:0] slot_t`.
- The same package is reused by the matching 4-slot transmitter.
- One sub-module is natural: `tdm_slot_ctr` holds the mod-4 counter with enable, load-to-1, and clear, and exposes a `last` signal for `slot` == 3.
- Shadow and output registers stay in the top level.

## Test plan
- Reset with `rst_n` = 0 for 2 cycles → all outputs 0, `locked` 0, `slot` 0. Beats without sync (values 5, 6, 7) → still 0 and unlocked.
- WIDTH = 4, 4 consecutive valid beats A, B, C, D with sync on A → `locked` = 1 after A. The cycle after D: `y0..y3` = A, B, C, D and `frame_valid` pulses once.
- Same frame with `din_valid` low for 3 cycles between B and C → identical outputs. `frame_valid` is delayed by exactly 3 cycles.
- Sync on the 3rd beat of a frame → `sync_err` pulse and `y*` unchanged. The next 3 beats complete a frame starting at that beat.
- Frame completes, then a 5th beat arrives without sync → `sync_err` pulse and `locked` = 0. Later beats are ignored until the next sync.
- `rst_n` asserted after 2 slots of a frame → all outputs 0 the next cycle. A fresh synced frame then decodes correctly.
